ej32_mem_arb: RTL and testbench

Byte-wide memory bus arbiter for the eJ32 core. It shares the single 8-bit memory port between three requesters:
- the branching/fetch unit (PC and operand fetch, jsr target reads)
- the load/store unit
- an IO/DMA port

It grants one owner at a time and holds multi-byte bursts atomically via a lock signal, capped at BURST_MAX beats. It routes the next-cycle read data back to the requester that issued the read.

---
 rtl/ej32_pkg.sv | 23 ++
 rtl/ej32_rr_pick.sv | 25 ++
 rtl/ej32_mem_arb.sv | 141 ++++++++++++++
 tb/tb_ej32_mem_arb.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ej32_pkg.sv
// Shared types and helpers for the eJ32 memory bus arbiter.
package ej32_pkg;

    typedef logic [0:0] arb_state_t;

    localparam arb_state_t aIDLE = 1'b0;
    localparam arb_state_t aOWN  = 1'b1;

    localparam int unsigned REQ_BR = 0;
    localparam int unsigned REQ_LS = 1;
    localparam int unsigned REQ_IO = 2;

    // Bits needed to hold values 0..n-1; never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/ej32_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after start_i wins.
module ej32_rr_pick #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   start_i,
    output logic [NREQ-1:0] gnt_o,
    output logic            vld_o
);

    always_comb begin
        gnt_o = '0;
        vld_o = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (!vld_o && req_i[j] && (j == ((32'(start_i) + i) % NREQ))) begin
                    gnt_o[j] = 1'b1;
                    vld_o    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ej32_mem_arb.sv
// Byte-wide memory bus arbiter for the eJ32 core with locked bursts capped at BURST_MAX beats.
// Define EJ32_ARB_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module ej32_mem_arb
    import ej32_pkg::*;
#(
    parameter int unsigned NREQ      = 3,
    parameter int unsigned ASZ       = 17,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ-1:0]   lock_i,
    input  logic [NREQ-1:0]   we_i,
    input  logic [NREQ*ASZ-1:0] addr_i,
    input  logic [NREQ*8-1:0] wdata_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic [NREQ-1:0]   rvld_o,
    output logic [7:0]        rdata_o,
    output logic [ASZ-1:0]    mem_addr_o,
    output logic              mem_we_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i,
    output logic              busy_o
);

    localparam int unsigned IW = cnt_width(NREQ);
    localparam int unsigned CW = cnt_width(BURST_MAX);

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] rvld_q, rvld_d;
    logic [ASZ-1:0]  addr_q, addr_d;

    logic [IW-1:0]   start;
    logic [NREQ-1:0] pick_gnt;
    logic            pick_vld;
    logic [IW-1:0]   pick_idx;

    logic            owned, own_req, own_lock, own_we, beat, release_bus;
    logic [ASZ-1:0]  own_addr;

`ifdef EJ32_ARB_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;
    assign start = ptr_q;
`else
    assign start = '0;
`endif

    ej32_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i   (req_i),
        .start_i (start),
        .gnt_o   (pick_gnt),
        .vld_o   (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (pick_gnt[j]) begin
                pick_idx = IW'(j);
            end
        end
    end

    assign owned    = (state_q == aOWN);
    assign own_req  = req_i[owner_q];
    assign own_lock = lock_i[owner_q];
    assign own_we   = we_i[owner_q];
    assign own_addr = addr_i[owner_q*ASZ +: ASZ];
    assign beat     = owned && own_req;

    // A cancel (owner dropped req) re-arbitrates exactly like a burst end.
    assign release_bus = !own_req || !own_lock || (cnt_q == CW'(BURST_MAX - 1));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rvld_d  = '0;
`ifdef EJ32_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        if (beat) begin
            addr_d = own_addr;
            if (!own_we) begin
                rvld_d = NREQ'(1) << owner_q;
            end
        end
        if (!owned || release_bus) begin
            cnt_d = '0;
            if (pick_vld) begin
                state_d = aOWN;
                owner_d = pick_idx;
`ifdef EJ32_ARB_RR_EN
                ptr_d   = (32'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
`endif
            end else begin
                state_d = aIDLE;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= aIDLE;
            owner_q <= '0;
            cnt_q   <= '0;
            rvld_q  <= '0;
            addr_q  <= '0;
`ifdef EJ32_ARB_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            rvld_q  <= rvld_d;
            addr_q  <= addr_d;
`ifdef EJ32_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign gnt_o       = owned ? (NREQ'(1) << owner_q) : '0;
    assign busy_o      = owned;
    assign rvld_o      = rvld_q;
    assign rdata_o     = mem_rdata_i;
    assign mem_addr_o  = beat ? own_addr : addr_q;
    assign mem_we_o    = beat && own_we;
    assign mem_wdata_o = wdata_i[owner_q*8 +: 8];

endmodule

// File: tb/tb_ej32_mem_arb.sv
// Self-checking bench for ej32_mem_arb: directed vector table, corner sequences, random vs model.
module tb_ej32_mem_arb;

    localparam int BMAX = 4;

    logic        clk;
    logic        rst;
    logic [2:0]  req_i, lock_i, we_i;
    logic [50:0] addr_i;
    logic [23:0] wdata_i;
    logic [2:0]  gnt_o, rvld_o;
    logic [7:0]  rdata_o, mem_wdata_o, mem_rdata_i;
    logic [16:0] mem_addr_o;
    logic        mem_we_o, busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [0:131071];

    ej32_mem_arb #(
        .NREQ      (3),
        .ASZ       (17),
        .BURST_MAX (BMAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .lock_i      (lock_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .rvld_o      (rvld_o),
        .rdata_o     (rdata_o),
        .mem_addr_o  (mem_addr_o),
        .mem_we_o    (mem_we_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .busy_o      (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory returns the byte one cycle after the address.
    always @(posedge clk) begin
        mem_rdata_i <= mem[mem_addr_o];
        if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
    end

    function automatic logic [7:0] memval(input logic [16:0] a);
        return a[7:0] ^ a[16:9] ^ 8'h3C;
    endfunction

    typedef struct {
        bit          rst;
        bit          chk;
        logic [2:0]  req, lock, we;
        logic [50:0] addr;
        logic [7:0]  wd;
        logic [2:0]  egnt, ervld;
        logic [7:0]  erd;
        bit          emwe;
        logic [16:0] emaddr;
    } vec_t;

    function automatic vec_t mk(input bit rst, input bit chk, input logic [2:0] req,
                                input logic [2:0] lock, input logic [2:0] we,
                                input logic [16:0] a0, input logic [16:0] a1,
                                input logic [16:0] a2, input logic [7:0] wd,
                                input logic [2:0] egnt, input logic [2:0] ervld,
                                input logic [7:0] erd, input bit emwe,
                                input logic [16:0] emaddr);
        vec_t v;
        v.rst = rst; v.chk = chk; v.req = req; v.lock = lock; v.we = we;
        v.addr = {a2, a1, a0}; v.wd = wd; v.egnt = egnt; v.ervld = ervld;
        v.erd = erd; v.emwe = emwe; v.emaddr = emaddr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst; req_i = v.req; lock_i = v.lock; we_i = v.we;
        addr_i = v.addr; wdata_i = {3{v.wd}};
        #4;
        if (v.chk) begin
            chk("gnt", gnt_o, v.egnt);
            chk("busy", busy_o, |v.egnt);
            chk("rvld", rvld_o, v.ervld);
            if (v.ervld != 3'b0) chk("rdata", rdata_o, v.erd);
            chk("mem_we", mem_we_o, v.emwe);
            chk("mem_addr", mem_addr_o, v.emaddr);
            if (v.emwe) chk("mem_wdata", mem_wdata_o, v.wd);
        end
        @(posedge clk);
        #1;
    endtask

    // Reference model: who owns the bus, how many beats taken, who gets read data next.
    int         m_own, m_beats, m_ptr, m_rv;
    logic [7:0] m_rvd;
    logic [16:0] m_last;
    logic [7:0] shadow [int];

    function automatic int pick(input logic [2:0] r, input int start);
        for (int i = 0; i < 3; i++) if (r[(start + i) % 3]) return (start + i) % 3;
        return -1;
    endfunction

    function automatic logic [7:0] mread(input logic [16:0] a);
        if (shadow.exists(int'(a))) return shadow[int'(a)];
        return memval(a);
    endfunction

    task automatic model_reset();
        m_own = -1; m_beats = 0; m_ptr = 0; m_rv = -1; m_rvd = 8'h0; m_last = '0;
    endtask

    task automatic model_cycle();
        int          o, w, nrv;
        bit          bt, ewe;
        logic [16:0] a;
        logic [7:0]  wd, nrvd;
        o = m_own; bt = 0; ewe = 0; a = m_last; wd = 8'h0; nrv = -1; nrvd = 8'h0;
        if (o >= 0 && req_i[o]) begin
            bt  = 1;
            ewe = we_i[o];
            a   = addr_i[o*17 +: 17];
            wd  = wdata_i[o*8 +: 8];
        end
        chk("rnd_gnt", gnt_o, (o >= 0) ? (32'd1 << o) : 32'd0);
        chk("rnd_busy", busy_o, o >= 0);
        chk("rnd_rvld", rvld_o, (m_rv >= 0) ? (32'd1 << m_rv) : 32'd0);
        if (m_rv >= 0) chk("rnd_rdata", rdata_o, m_rvd);
        chk("rnd_mem_we", mem_we_o, ewe);
        chk("rnd_mem_addr", mem_addr_o, a);
        if (ewe) chk("rnd_mem_wdata", mem_wdata_o, wd);
        if (bt) begin
            m_last = a;
            m_beats++;
            if (ewe) shadow[int'(a)] = wd;
            else begin nrv = o; nrvd = mread(a); end
        end
        m_rv = nrv; m_rvd = nrvd;
        if (o < 0 || !bt || !lock_i[o] || m_beats == BMAX) begin
`ifdef EJ32_ARB_RR_EN
            w = pick(req_i, m_ptr);
`else
            w = pick(req_i, 0);
`endif
            m_own = w; m_beats = 0;
            if (w >= 0) m_ptr = (w + 1) % 3;
        end
        if (rst) model_reset();
    endtask

    vec_t tbl[$];

    initial begin
        for (int i = 0; i < 131072; i++) mem[i] = memval(17'(i));
        rst = 1'b1; req_i = '0; lock_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;

        // Reset, single read, single write, three-way contention.
        tbl.push_back(mk(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3'b001, 0, 0, 17'h100, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3'b001, 0, 0, 17'h100, 0, 0, 0, 3'b001, 3'b000, 0, 0, 17'h100));
        tbl.push_back(mk(0, 1, 3'b000, 0, 0, 17'h100, 0, 0, 0, 3'b001, 3'b001,
                         memval(17'h100), 0, 17'h100));
        tbl.push_back(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 17'h100));
        tbl.push_back(mk(0, 1, 3'b100, 0, 3'b100, 0, 0, 17'h1FFFF, 8'hA5, 3'b000, 3'b000, 0, 0,
                         17'h100));
        tbl.push_back(mk(0, 1, 3'b100, 0, 3'b100, 0, 0, 17'h1FFFF, 8'hA5, 3'b100, 3'b000, 0, 1,
                         17'h1FFFF));
        tbl.push_back(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b100, 3'b000, 0, 0, 17'h1FFFF));
        tbl.push_back(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 17'h1FFFF));
        tbl.push_back(mk(0, 1, 3'b111, 0, 0, 17'h10, 17'h11, 17'h12, 0, 3'b000, 3'b000, 0, 0,
                         17'h1FFFF));
`ifdef EJ32_ARB_RR_EN
        tbl.push_back(mk(0, 1, 3'b111, 0, 0, 17'h10, 17'h11, 17'h12, 0, 3'b001, 3'b000, 0, 0,
                         17'h10));
        tbl.push_back(mk(0, 1, 3'b111, 0, 0, 17'h10, 17'h11, 17'h12, 0, 3'b010, 3'b001,
                         memval(17'h10), 0, 17'h11));
        tbl.push_back(mk(0, 1, 3'b111, 0, 0, 17'h10, 17'h11, 17'h12, 0, 3'b100, 3'b010,
                         memval(17'h11), 0, 17'h12));
        tbl.push_back(mk(0, 1, 3'b111, 0, 0, 17'h10, 17'h11, 17'h12, 0, 3'b001, 3'b100,
                         memval(17'h12), 0, 17'h10));
        tbl.push_back(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b010, 3'b001, memval(17'h10), 0,
                         17'h10));
`else
        tbl.push_back(mk(0, 1, 3'b111, 0, 0, 17'h10, 17'h11, 17'h12, 0, 3'b001, 3'b000, 0, 0,
                         17'h10));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0, 1, 3'b111, 0, 0, 17'h10, 17'h11, 17'h12, 0, 3'b001, 3'b001,
                             memval(17'h10), 0, 17'h10));
        tbl.push_back(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b001, 3'b001, memval(17'h10), 0,
                         17'h10));
`endif
        tbl.push_back(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 17'h10));
        foreach (tbl[i]) apply(tbl[i]);

        // Locked burst by requester 1, forced release after BURST_MAX beats.
        apply(mk(0, 1, 3'b010, 3'b010, 0, 0, 17'h200, 0, 0, 3'b000, 3'b000, 0, 0, 17'h10));
        apply(mk(0, 1, 3'b010, 3'b010, 0, 0, 17'h200, 0, 0, 3'b010, 3'b000, 0, 0, 17'h200));
        apply(mk(0, 1, 3'b010, 3'b010, 0, 0, 17'h201, 0, 0, 3'b010, 3'b010, memval(17'h200), 0,
                 17'h201));
        apply(mk(0, 1, 3'b010, 3'b010, 0, 0, 17'h202, 0, 0, 3'b010, 3'b010, memval(17'h201), 0,
                 17'h202));
        apply(mk(0, 1, 3'b011, 3'b010, 0, 17'h700, 17'h203, 0, 0, 3'b010, 3'b010,
                 memval(17'h202), 0, 17'h203));
        apply(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b001, 3'b010, memval(17'h203), 0, 17'h203));
        apply(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 17'h203));

        // Owner 0 cancels mid-lock while requester 1 waits.
        apply(mk(0, 1, 3'b001, 3'b001, 0, 17'h300, 0, 0, 0, 3'b000, 3'b000, 0, 0, 17'h203));
        apply(mk(0, 1, 3'b001, 3'b001, 0, 17'h300, 0, 0, 0, 3'b001, 3'b000, 0, 0, 17'h300));
        apply(mk(0, 1, 3'b010, 0, 0, 0, 17'h400, 0, 0, 3'b001, 3'b001, memval(17'h300), 0,
                 17'h300));
        apply(mk(0, 1, 3'b010, 0, 0, 0, 17'h400, 0, 0, 3'b010, 3'b000, 0, 0, 17'h400));
        apply(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b010, 3'b010, memval(17'h400), 0, 17'h400));
        apply(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 17'h400));

        // Reset at beat 2 of a locked read burst.
        apply(mk(0, 1, 3'b001, 3'b001, 0, 17'h500, 0, 0, 0, 3'b000, 3'b000, 0, 0, 17'h400));
        apply(mk(0, 1, 3'b001, 3'b001, 0, 17'h500, 0, 0, 0, 3'b001, 3'b000, 0, 0, 17'h500));
        apply(mk(0, 1, 3'b001, 3'b001, 0, 17'h501, 0, 0, 0, 3'b001, 3'b001, memval(17'h500), 0,
                 17'h501));
        apply(mk(1, 1, 3'b001, 3'b001, 0, 17'h502, 0, 0, 0, 3'b001, 3'b001, memval(17'h501), 0,
                 17'h502));
        apply(mk(0, 1, 3'b010, 0, 0, 0, 17'h600, 0, 0, 3'b000, 3'b000, 0, 0, 17'h0));
        apply(mk(0, 1, 3'b010, 0, 0, 0, 17'h600, 0, 0, 3'b010, 3'b000, 0, 0, 17'h600));
        apply(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b010, 3'b010, memval(17'h600), 0, 17'h600));
        apply(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 17'h600));

        // Randomized traffic against the model, in an address window the directed part never used.
        rst = 1'b1; req_i = '0; lock_i = '0; we_i = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            for (int k = 0; k < 3; k++) begin
                req_i[k]          = ($urandom_range(0, 7) < 5);
                lock_i[k]         = ($urandom_range(0, 1) == 1);
                we_i[k]           = ($urandom_range(0, 9) < 3);
                addr_i[k*17 +: 17] = 17'h10000 + 17'($urandom_range(0, 15));
                wdata_i[k*8 +: 8]  = 8'($urandom);
            end
            #4;
            model_cycle();
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
